// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rfState_t;

  localparam int ZERO_REG = 0;

  function automatic int depthOf(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: sweeps entries 1..DEPTH-1 to zero, one per cycle,
// then raises ready. State is exported on stateDbg for observation.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output rfState_t          stateDbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  rfState_t          state;
  rfState_t          stateNext;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ptrNext;
  logic              readyNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= FIRST_ADDR;
      ready   <= 1'b0;
    end else begin
      state   <= stateNext;
      clr_ptr <= ptrNext;
      ready   <= readyNext;
    end
  end

  // Entry 0 is never swept: it is hardwired to zero on the read side.
  always_comb begin
    stateNext = state;
    ptrNext   = clr_ptr;
    readyNext = ready;
    clr_we    = 1'b0;
    clr_addr  = clr_ptr;
    case (state)
      CLEAR: begin
        clr_we  = !rst;
        ptrNext = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_ADDR) begin
          stateNext = RUN;
          readyNext = 1'b1;
        end
      end
      RUN: begin
        stateNext = RUN;
      end
      default: begin
        stateNext = CLEAR;
        readyNext = 1'b0;
      end
    endcase
  end

  assign stateDbg = state;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// register 0 reads as zero. REGFILE_BYPASS_EN forwards busW to matching lanes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        Rw,
  input  logic [DATA_W-1:0]        busW,
  input  logic [NUM_RD*ADDR_W-1:0] Ra,
  output logic [NUM_RD*DATA_W-1:0] busA,
  output logic                     ready
);

  localparam int DEPTH = depthOf(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regi [DEPTH];

  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;
  rfState_t          fsmState;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) uClearFsm (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clrWe),
    .clr_addr(clrAddr),
    .ready   (ready),
    .stateDbg(fsmState)
  );

  logic              runMode;
  logic              userWe;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  assign runMode = (fsmState == RUN) && !rst;
  assign userWe  = runMode && RegWr && (Rw != ZERO_ADDR);

  // The sweep owns the write port while clearing; user writes are dropped then.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = Rw;
    wrData = busW;
    if (clrWe) begin
      wrEn   = 1'b1;
      wrAddr = clrAddr;
      wrData = '0;
    end else if (userWe) begin
      wrEn   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      regi[wrAddr] <= wrData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRead
    logic [ADDR_W-1:0] raK;
    logic [DATA_W-1:0] rdData;

    assign raK = Ra[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdData = '0;
      if (runMode && (raK != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
        if (userWe && (raK == Rw)) begin
          rdData = busW;
        end else begin
          rdData = regi[raK];
        end
`else
        rdData = regi[raK];
`endif
      end
    end

    assign busA[k*DATA_W +: DATA_W] = rdData;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk;
  logic                     rst;
  logic                     RegWr;
  logic [ADDR_W-1:0]        Rw;
  logic [DATA_W-1:0]        busW;
  logic [NUM_RD*ADDR_W-1:0] Ra;
  logic [NUM_RD*DATA_W-1:0] busA;
  logic                     ready;

  regfile_mp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .RegWr(RegWr),
    .Rw   (Rw),
    .busW (busW),
    .Ra   (Ra),
    .busA (busA),
    .ready(ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int nChecks = 0;
  int nFails  = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane(input int k);
    return busA[k*DATA_W +: DATA_W];
  endfunction

  // ---------------- behavioural model ----------------
  // Register contents as a plain array; after reset, the n-th non-reset edge
  // zeroes entry n, and the array is usable once all DEPTH-1 entries are done.
  logic [DATA_W-1:0] mem [DEPTH];
  bit  mValid  = 1'b0;
  bit  mReady  = 1'b0;
  int  sweepN  = 0;

  always @(posedge clk) begin
    if (rst) begin
      mValid = 1'b1;
      mReady = 1'b0;
      sweepN = 0;
    end else if (mValid) begin
      if (!mReady) begin
        sweepN++;
        mem[sweepN] = '0;
        if (sweepN == DEPTH - 1) mReady = 1'b1;
      end else if (RegWr && Rw != 0) begin
        mem[Rw] = busW;
      end
    end
  end

  function automatic logic [DATA_W-1:0] expLane(input int k);
    int a;
    a = int'(Ra[k*ADDR_W +: ADDR_W]);
    if (!mReady || rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWr && Rw != 0 && int'(Rw) == a) return busW;
`endif
    return mem[a];
  endfunction

  // Compare process: outputs are meaningful once the first reset has been seen.
  always @(negedge clk) begin
    if (mValid) begin
      check("ready_model", {63'd0, ready}, {63'd0, mReady});
      for (int k = 0; k < NUM_RD; k++) begin
        check($sformatf("busA_lane%0d_model", k), {32'd0, lane(k)}, {32'd0, expLane(k)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRa(input int a0, input int a1);
    Ra = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic writeReg(input int addr, input logic [DATA_W-1:0] data);
    RegWr = 1'b1;
    Rw    = ADDR_W'(addr);
    busW  = data;
    tick();
    RegWr = 1'b0;
  endtask

  task automatic waitReady(output int edges);
    edges = 0;
    while (!ready && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int edges;
    int cyc;
    logic [DATA_W-1:0] got;
    rst   = 1'b0;
    RegWr = 1'b0;
    Rw    = '0;
    busW  = '0;
    Ra    = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset sweep
    rst = 1'b1;
    tick();
    tick();
    check("ready_during_reset", {63'd0, ready}, 64'd0);
    rst = 1'b0;
    setRa(3, 31);
    #1;
    check("busA_clear_lane0", {32'd0, lane(0)}, 64'd0);
    waitReady(edges);
    check("sweep_edges", 64'(edges), 64'd31);
    for (int a = 0; a < DEPTH; a++) begin
      setRa(a, DEPTH - 1 - a);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        got = exp_q.pop_front();
        check("readback_after_sweep", {32'd0, lane(k)}, {32'd0, got});
      end
      tick();
    end

    // Basic write/read on both lanes
    writeReg(5, 32'hDEADBEEF);
    setRa(5, 5);
    #1;
    check("basic_lane0", {32'd0, lane(0)}, 64'hDEADBEEF);
    check("basic_lane1", {32'd0, lane(1)}, 64'hDEADBEEF);
    tick();

    // Zero register is not writable
    writeReg(0, 32'hFFFFFFFF);
    setRa(0, 5);
    #1;
    check("zero_reg_lane0", {32'd0, lane(0)}, 64'd0);
    check("zero_reg_other_lane", {32'd0, lane(1)}, 64'hDEADBEEF);
    tick();

    // Same-cycle read-after-write
    writeReg(9, 32'h11111111);
    setRa(9, 0);
    RegWr = 1'b1;
    Rw    = ADDR_W'(9);
    busW  = 32'h22222222;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_same_cycle", {32'd0, lane(0)}, 64'h22222222);
`else
    check("raw_same_cycle", {32'd0, lane(0)}, 64'h11111111);
`endif
    tick();
    RegWr = 1'b0;
    #1;
    check("raw_next_cycle", {32'd0, lane(0)}, 64'h22222222);
    tick();

    // Write during CLEAR is dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    RegWr = 1'b1;
    Rw    = ADDR_W'(7);
    busW  = 32'h12345678;
    tick();
    RegWr = 1'b0;
    waitReady(edges);
    check("sweep_edges_after_clear_write", 64'(edges), 64'd28);
    setRa(7, 5);
    #1;
    check("clear_write_dropped", {32'd0, lane(0)}, 64'd0);
    check("old_reg5_cleared", {32'd0, lane(1)}, 64'd0);
    tick();

    // Reset mid-RUN
    writeReg(3, 32'hA5A5A5A5);
    setRa(3, 3);
    #1;
    check("reg3_before_reset", {32'd0, lane(1)}, 64'hA5A5A5A5);
    rst = 1'b1;
    tick();
    check("ready_drops_on_reset", {63'd0, ready}, 64'd0);
    rst = 1'b0;
    waitReady(edges);
    check("sweep_edges_mid_run", 64'(edges), 64'd31);
    #1;
    check("reg3_after_reset", {32'd0, lane(0)}, 64'd0);
    tick();

    // Randomized traffic, checked every cycle by the compare process
    cyc = 0;
    while (cyc < 3000) begin
      RegWr = ($urandom_range(0, 2) != 0);
      Rw    = ADDR_W'($urandom_range(0, DEPTH - 1));
      busW  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        Ra = {Rw, Rw};
      end else begin
        Ra = NUM_RD*ADDR_W'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      cyc++;
    end
    rst   = 1'b0;
    RegWr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before limit");
    $fatal(1, "timeout");
  end

endmodule
